// File: rtl/pe_inst_fetch_ctrl.sv
// Instruction-fetch sequencer for a PE's registered-read instruction ROM: walks 0..numInst-1, numIter times.
// Two output slots (output register plus skid) absorb the one-cycle ROM latency under stall.
module pe_inst_fetch_ctrl #(
  parameter int addrLen = 5,
  parameter int dataLen = 32,
  parameter int iterLen = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addrLen:0]   numInst,
  input  logic [iterLen-1:0] numIter,
  input  logic [dataLen-1:0] romData,
  input  logic               stall,
  output logic [addrLen-1:0] rdAddr,
  output logic [dataLen-1:0] instOut,
  output logic               instValid,
  output logic               instLast,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam logic [addrLen:0]   MaxInst = {1'b1, {addrLen{1'b0}}};
  localparam logic [addrLen:0]   OneInst = {{addrLen{1'b0}}, 1'b1};
  localparam logic [iterLen-1:0] OneIter = {{(iterLen-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [addrLen-1:0]   pc_q, pc_d;
  logic [iterLen-1:0]   iter_q, iter_d;
  logic [addrLen:0]     num_inst_q, num_inst_d;
  logic [iterLen-1:0]   num_iter_q, num_iter_d;
  logic                 infl_vld_q, infl_vld_d;
  logic                 infl_last_q, infl_last_d;
  logic                 out_vld_q, out_vld_d;
  logic [dataLen-1:0]   out_dat_q, out_dat_d;
  logic                 out_last_q, out_last_d;
  logic                 skid_vld_q, skid_vld_d;
  logic [dataLen-1:0]   skid_dat_q, skid_dat_d;
  logic                 skid_last_q, skid_last_d;

  logic       xfer;
  logic       out_free;
  logic [1:0] occ;
  logic       issue_ok;
  logic       pc_last;
  logic       iter_last;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    iter_d      = iter_q;
    num_inst_d  = num_inst_q;
    num_iter_d  = num_iter_q;
    infl_vld_d  = 1'b0;
    infl_last_d = 1'b0;
    out_vld_d   = out_vld_q;
    out_dat_d   = out_dat_q;
    out_last_d  = out_last_q;
    skid_vld_d  = skid_vld_q;
    skid_dat_d  = skid_dat_q;
    skid_last_d = skid_last_q;

    xfer      = out_vld_q && !stall;
    out_free  = xfer || !out_vld_q;
    occ       = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(infl_vld_q);
    issue_ok  = (occ < (xfer ? 2'd3 : 2'd2));
    pc_last   = ({1'b0, pc_q} == (num_inst_q - OneInst));
    iter_last = (iter_q == (num_iter_q - OneIter));

    // Skid entry always leaves before the ROM word arriving this cycle.
    if (out_free) begin
      if (skid_vld_q) begin
        out_vld_d   = 1'b1;
        out_dat_d   = skid_dat_q;
        out_last_d  = skid_last_q;
        skid_vld_d  = infl_vld_q;
        skid_dat_d  = infl_vld_q ? romData : skid_dat_q;
        skid_last_d = infl_vld_q && infl_last_q;
      end else begin
        out_vld_d  = infl_vld_q;
        out_dat_d  = infl_vld_q ? romData : out_dat_q;
        out_last_d = infl_vld_q && infl_last_q;
      end
    end else if (infl_vld_q) begin
      skid_vld_d  = 1'b1;
      skid_dat_d  = romData;
      skid_last_d = infl_last_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_inst_d = (numInst > MaxInst) ? MaxInst : numInst;
          num_iter_d = numIter;
          pc_d       = '0;
          iter_d     = '0;
          state_d    = ((numInst == '0) || (numIter == '0)) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (issue_ok) begin
          infl_vld_d  = 1'b1;
          infl_last_d = pc_last;
          if (pc_last) begin
            pc_d   = '0;
            iter_d = iter_q + OneIter;
            if (iter_last) state_d = S_DRAIN;
          end else begin
            pc_d = pc_q + addrLen'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!infl_vld_q && !skid_vld_q && out_free) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      iter_q      <= '0;
      num_inst_q  <= '0;
      num_iter_q  <= '0;
      infl_vld_q  <= 1'b0;
      infl_last_q <= 1'b0;
      out_vld_q   <= 1'b0;
      out_dat_q   <= '0;
      out_last_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_dat_q  <= '0;
      skid_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      iter_q      <= iter_d;
      num_inst_q  <= num_inst_d;
      num_iter_q  <= num_iter_d;
      infl_vld_q  <= infl_vld_d;
      infl_last_q <= infl_last_d;
      out_vld_q   <= out_vld_d;
      out_dat_q   <= out_dat_d;
      out_last_q  <= out_last_d;
      skid_vld_q  <= skid_vld_d;
      skid_dat_q  <= skid_dat_d;
      skid_last_q <= skid_last_d;
    end
  end

  assign rdAddr    = pc_q;
  assign instOut   = out_dat_q;
  assign instValid = out_vld_q;
  assign instLast  = out_last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: doc/pe_inst_fetch_ctrl.md
# pe_inst_fetch_ctrl

Instruction-fetch sequencer for one PE's instruction ROM (`iBuffer`). On `start` it walks the ROM address space from 0 to `numInst-1` and repeats the walk `numIter` times. It absorbs the ROM's one-cycle registered read latency and supports downstream back-pressure without losing or duplicating instructions. It sits between the PE control logic and `iBuffer`, and owns `rdAddr`.

## Interface
- `addrLen`, 5, ROM address width; must match `iBuffer.addrLen`
- `dataLen`, 32, instruction width; must match `iBuffer.dataLen`
- `iterLen`, 16, width of the iteration count
- `clk`  in  1  clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a program run; sampled only in IDLE
- `numInst`  in  addrLen+1  instructions per iteration, latched on accepted `start`; values above 2^addrLen clamp to 2^addrLen
- `numIter`  in  iterLen  iteration count, latched on accepted `start`
- `romData`  in  dataLen  `iBuffer.dataOut`; holds mem[rdAddr sampled at the previous edge]
- `stall`  in  1  consumer not ready; a transfer occurs when `instValid && !stall`
- `rdAddr`  out  addrLen  registered ROM read address
- `instOut`  out  dataLen  instruction presented to the PE
- `instValid`  out  1  `instOut` valid
- `instLast`  out  1  `instOut` is the final instruction of an iteration
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  single-cycle pulse when the run completes

## Operation
- States and transitions:
  - IDLE → FETCH on `start`.
  - FETCH → DRAIN after the final address of the final iteration is issued.
  - DRAIN → DONE when no issued instruction remains untransferred.
  - DONE → IDLE unconditionally after 1 cycle.
- Degenerate runs: if the latched `numInst==0` or `numIter==0`, IDLE → DONE directly. No address is issued and no instruction is presented.
- `start` is ignored outside IDLE.
- Issue: an issue drives address `pc` on `rdAddr` and marks it in flight.
- Address sequencing:
  - `pc` increments on each issue.
  - At `pc==numInst-1`, `pc` wraps to 0 and the iteration counter increments.
  - With `numInst==2^addrLen`, the wrap is the natural addrLen-bit overflow.
- Each in-flight tag carries a `last` bit, set when `pc==numInst-1`; it becomes `instLast`.
- Buffering: the output register plus a 1-entry skid register give 2 slots.
  - An issue is allowed only if (occupied slots + in-flight reads − transfers this cycle) < 2.
  - Data is therefore never dropped while `stall` is high.
- Ordering: instructions leave strictly in issue order.
  - Each instruction is presented exactly once per iteration, with the sequence repeated `numIter` times.
  - The skid entry drains before newer ROM data.
- When no issue occurs, `rdAddr` holds its last value; the ROM re-reads it harmlessly because the data is untagged.
- `done` pulses for exactly 1 cycle in DONE, then the block returns to IDLE.

## Timing
- Reset values: `rdAddr`=0, `instOut`=0, `instValid`=0, `instLast`=0, `busy`=0, `done`=0, state IDLE, counters 0, skid empty.
- `reset` asserted mid-run:
  - Clears everything at that edge, including in-flight reads.
  - No `done` pulse is produced.
  - `start` sampled in the same cycle as `reset` is ignored.
- Latency, with `start` sampled at edge E0:
  - `rdAddr`=0 and `busy`=1 after E0.
  - ROM output = mem[0] after E1.
  - `instValid`=1 with `instOut`=mem[0] after E2.
- Throughput is 1 instruction/cycle with `stall` held low.
- Stall handling:
  - With `stall` high, `instOut`, `instValid` and `instLast` hold stable.
  - Issue stops within 1 cycle.
  - After `stall` falls, transfers resume on the next cycle with no bubble, because the skid entry is full.
- `done` asserts the cycle after the last transfer; `busy` falls the cycle after `done`.
- Degenerate run: `done` pulses the cycle after `start` is sampled.

## Test plan
- numInst=4, numIter=1, stall=0, ROM mem[i]=i → `instOut` 0,1,2,3 on 4 consecutive cycles starting 2 cycles after `start`; `instLast` only on 3; `done` one cycle later.
- numInst=3, numIter=3 → sequence 0,1,2 ×3 (9 transfers); `instLast` on each 2; `rdAddr` wraps 2→0; exactly one `done`.
- numInst=8, random `stall` (50%) → transferred sequence is exactly 0..7, with no duplicates or drops; outputs are stable on every stalled cycle.
- numInst=0 or numIter=0 → `done` the cycle after `start`; `instValid` never asserts; `start` during `busy` is ignored.
- numInst=2^addrLen=32, numIter=2 → 64 transfers 0..31,0..31; `numInst`=40 clamps to 32.
- `reset` raised after 5 transfers of a 16-instruction run → all outputs 0 on the next cycle, no `done`; a fresh `start` restarts from address 0.
